pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised fetch program counter for the MIPS32 core; successor to the single-mode PC.
//   Holds the word-aligned fetch address [31:2] and redirects it on exception, ERET or jump/branch.
//   Adds stall, a valid/ready fetch handshake to instruction memory, EPC capture with an EXL flag,
//   and a count of accepted fetches. Sits between the decode/control path and the instruction memory port.
// PARAMETERS
//   RESET_ADDR   32'h0000_3000  byte address loaded on reset; bits [1:0] must be 0
//   EXC_VECTOR   32'h0000_4180  byte address of the exception handler; bits [1:0] must be 0
//   STEP         1              word increment per accepted fetch (1..4)
//   CNT_WIDTH    32             width of fetch_count
// PORTS
//   clock          in   1          rising-edge clock
//   reset          in   1          asynchronous, active-high reset
//   stall          in   1          pipeline stall: hold PC, no increment
//   jump_enable    in   1          jump/branch redirect request
//   jump_input     in   [31:2]     redirect target (word address)
//   exception      in   1          exception raised by the pipeline
//   exc_epc        in   [31:2]     word address of the faulting instruction
//   eret           in   1          return from exception
//   fetch_ready    in   1          instruction memory accepts the current request
//   fetch_valid    out  1          request on pc_value is valid
//   pc_value       out  [31:2]     current fetch word address
//   epc_value      out  [31:2]     captured exception PC
//   exl            out  1          exception level: 1 while in the handler
//   fetch_count    out  CNT_WIDTH  number of accepted fetches since reset, wraps
// BEHAVIOUR
//   Reset (async, immediate, no clock edge needed): pc_value=RESET_ADDR[31:2], epc_value=0, exl=0,
//     fetch_valid=0, fetch_count=0, state=BOOT.
//   FSM states:
//     BOOT: fetch_valid=0; next edge -> RUN. pc_value does not change in BOOT.
//     RUN:  fetch_valid=1.
//   Per-edge update priority in RUN (highest first):
//     1 exception && !exl: pc<=EXC_VECTOR[31:2]; epc<=exc_epc; exl<=1
//     2 eret && exl:       pc<=epc_value; exl<=0
//     3 jump_enable:       pc<=jump_input
//     4 stall || !fetch_ready: pc held
//     5 otherwise (accepted fetch): pc<=pc+STEP
//   Masking: exception while exl=1 is ignored, epc not overwritten.
//     eret while exl=0 is ignored and falls through to rules 3-5.
//   Redirects (1-3) take effect even when stall=1 or fetch_ready=0; the in-flight request is dropped.
//   fetch_count increments by 1 on each edge with fetch_valid && fetch_ready && !stall,
//     whether or not a redirect also happens on that edge.
//   Arithmetic: pc+STEP is 30-bit modulo; 30'h3FFF_FFFF+1 -> 30'h0000_0000. fetch_count wraps likewise.
//   Latency: every update is visible one cycle after the sampling edge. Outputs are registered; no comb paths in->out.
//   Reset mid-operation clears exl and epc and returns to BOOT, regardless of any pending redirect.
// STRUCTURE
//   Shared package (mips_pkg): RESET_ADDR / EXC_VECTOR defaults, pc_state_t enum {BOOT, RUN}.
//   Put the next-PC priority mux in one combinational sub-module, pc_next_sel.
//   Keep pc, epc, exl, state and counter registers in pc_sequencer.
// TESTING
//   1 Assert reset mid-cycle -> pc_value=0xC00 before any clock edge; fetch_valid=0. Release -> fetch_valid=1 after one edge.
//   2 RUN with fetch_ready=1: pc 0xC00->0xC01->0xC02; fetch_count 0->1->2.
//     fetch_ready=0 or stall=1 for 2 cycles -> pc holds 0xC02 and fetch_count holds.
//   3 jump_enable=1, jump_input=0x1000F00D with stall=1 -> pc=0x1000F00D next cycle.
//     Release both -> 0x1000F00E.
//   4 exception=1, exc_epc=0xC05, jump_enable=1 -> pc=0x1060, epc=0xC05, exl=1.
//     Second exception with exc_epc=0xAAA -> epc stays 0xC05. eret -> pc=0xC05, exl=0.
//   5 STEP=1, jump to 0x3FFFFFFF, accept -> pc=0x00000000.
//     eret with exl=0 and jump_enable=0 -> plain increment.
//   6 reset=1 together with exception, jump and eret -> pc=0xC00, exl=0, epc=0, fetch_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 fetch front end: default addresses and PC sequencer states.
package mips_pkg;

    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_EXC,
        SEL_ERET,
        SEL_JUMP,
        SEL_INC
    } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: exception > ERET > jump > hold > increment, with EXL masking.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          STEP       = 1
) (
    input  logic        i_run,
    input  logic [29:0] i_pc,
    input  logic [29:0] i_epc,
    input  logic        i_exl,
    input  logic        i_exception,
    input  logic [29:0] i_exc_epc,
    input  logic        i_eret,
    input  logic        i_jump_enable,
    input  logic [29:0] i_jump_input,
    input  logic        i_stall,
    input  logic        i_fetch_ready,
    output logic [29:0] o_pc,
    output logic [29:0] o_epc,
    output logic        o_exl
);

    localparam logic [29:0] STEP_W = 30'(STEP);

    pc_sel_t w_sel;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_sel = SEL_HOLD;
        if (i_run) begin
            if (i_exception && !i_exl)
                w_sel = SEL_EXC;
            else if (i_eret && i_exl)
                w_sel = SEL_ERET;
            else if (i_jump_enable)
                w_sel = SEL_JUMP;
            else if (!i_stall && i_fetch_ready)
                w_sel = SEL_INC;
        end
    end

    always_comb begin
        o_pc  = i_pc;
        o_epc = i_epc;
        o_exl = i_exl;
        case (w_sel)
            SEL_EXC: begin
                o_pc  = EXC_VECTOR[31:2];
                o_epc = i_exc_epc;
                o_exl = 1'b1;
            end
            SEL_ERET: begin
                o_pc  = i_epc;
                o_exl = 1'b0;
            end
            SEL_JUMP: o_pc = i_jump_input;
            SEL_INC:  o_pc = i_pc + STEP_W;
            default:  o_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with stall, valid/ready fetch handshake, EPC/EXL capture and fetch counter.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          STEP       = 1,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 jump_enable,
    input  logic [31:2]          jump_input,
    input  logic                 exception,
    input  logic [31:2]          exc_epc,
    input  logic                 eret,
    input  logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [31:2]          pc_value,
    output logic [31:2]          epc_value,
    output logic                 exl,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    pc_state_t            r_state;
    logic [29:0]          r_pc;
    logic [29:0]          r_epc;
    logic                 r_exl;
    logic                 r_fetch_valid;
    logic [CNT_WIDTH-1:0] r_fetch_count;

    logic [29:0] w_next_pc;
    logic [29:0] w_next_epc;
    logic        w_next_exl;
    logic        w_accept;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR),
        .STEP       (STEP)
    ) u_next_sel (
        .i_run         (r_state == RUN),
        .i_pc          (r_pc),
        .i_epc         (r_epc),
        .i_exl         (r_exl),
        .i_exception   (exception),
        .i_exc_epc     (exc_epc),
        .i_eret        (eret),
        .i_jump_enable (jump_enable),
        .i_jump_input  (jump_input),
        .i_stall       (stall),
        .i_fetch_ready (fetch_ready),
        .o_pc          (w_next_pc),
        .o_epc         (w_next_epc),
        .o_exl         (w_next_exl)
    );

    // A fetch counts as accepted even when a redirect drops it on the same edge.
    assign w_accept = r_fetch_valid && fetch_ready && !stall;

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_ADDR[31:2];
            r_epc         <= '0;
            r_exl         <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN: begin
                    r_pc  <= w_next_pc;
                    r_epc <= w_next_epc;
                    r_exl <= w_next_exl;
                    if (w_accept)
                        r_fetch_count <= r_fetch_count + CNT_WIDTH'(1);
                end
                default: begin
                    r_state       <= BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign pc_value    = r_pc;
    assign epc_value   = r_epc;
    assign exl         = r_exl;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then randomized traffic against a reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam int          STEP       = 1;
    localparam int          CNT_WIDTH  = 32;
    localparam longint      PC_MOD     = 64'd1 << 30;
    localparam longint      CNT_MOD    = 64'd1 << CNT_WIDTH;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset = 1'b0;
    logic                 stall = 1'b0;
    logic                 jump_enable = 1'b0;
    logic [31:2]          jump_input = '0;
    logic                 exception = 1'b0;
    logic [31:2]          exc_epc = '0;
    logic                 eret = 1'b0;
    logic                 fetch_ready = 1'b0;
    logic                 fetch_valid;
    logic [31:2]          pc_value;
    logic [31:2]          epc_value;
    logic                 exl;
    logic [CNT_WIDTH-1:0] fetch_count;

    pc_sequencer #(
        .RESET_ADDR (RESET_ADDR),
        .EXC_VECTOR (EXC_VECTOR),
        .STEP       (STEP),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .jump_enable (jump_enable),
        .jump_input  (jump_input),
        .exception   (exception),
        .exc_epc     (exc_epc),
        .eret        (eret),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .pc_value    (pc_value),
        .epc_value   (epc_value),
        .exl         (exl),
        .fetch_count (fetch_count)
    );

    typedef struct {
        longint pc;
        longint epc;
        bit     exl;
        bit     valid;
        longint cnt;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: architectural state only, updated from the rules in priority order.
    longint m_pc, m_epc, m_cnt;
    bit     m_exl, m_running;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = longint'(RESET_ADDR) / 4;
        m_epc     = 0;
        m_exl     = 0;
        m_cnt     = 0;
        m_running = 0;
    endtask

    task automatic model_edge();
        bit accepted;
        if (!m_running) begin
            m_running = 1;
            return;
        end
        accepted = fetch_ready && !stall;
        if (accepted) m_cnt = (m_cnt + 1) % CNT_MOD;
        if (exception && !m_exl) begin
            m_epc = longint'(exc_epc);
            m_pc  = longint'(EXC_VECTOR) / 4;
            m_exl = 1;
        end else if (eret && m_exl) begin
            m_pc  = m_epc;
            m_exl = 0;
        end else if (jump_enable) begin
            m_pc = longint'(jump_input);
        end else if (accepted) begin
            m_pc = (m_pc + STEP) % PC_MOD;
        end
    endtask

    // Inputs are already driven; model the edge, then publish the expectation once it has happened.
    task automatic cycle();
        exp_t e;
        model_edge();
        @(posedge clock);
        e.pc = m_pc; e.epc = m_epc; e.exl = m_exl; e.valid = m_running; e.cnt = m_cnt;
        sb_q.push_back(e);
        #2;
    endtask

    task automatic drive(input bit st, input bit rdy, input bit jmp, input longint tgt,
                         input bit exc, input longint epc_in, input bit ert);
        stall       = st;
        fetch_ready = rdy;
        jump_enable = jmp;
        jump_input  = tgt[29:0];
        exception   = exc;
        exc_epc     = epc_in[29:0];
        eret        = ert;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    longint'(pc_value), longint'(RESET_ADDR) / 4);
        check({tag, "_valid"}, longint'(fetch_valid), 0);
        check({tag, "_exl"},   longint'(exl), 0);
        check({tag, "_epc"},   longint'(epc_value), 0);
        check({tag, "_cnt"},   longint'(fetch_count), 0);
    endtask

    // Reset lands mid-cycle, after the monitor has consumed the pending expectation.
    task automatic apply_reset(input string tag);
        @(negedge clock);
        #1 reset = 1'b1;
        #1 check_reset_values(tag);
        model_reset();
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("pc",    longint'(pc_value),    e.pc);
            check("epc",   longint'(epc_value),   e.epc);
            check("exl",   longint'(exl),         longint'(e.exl));
            check("valid", longint'(fetch_valid), longint'(e.valid));
            check("count", longint'(fetch_count), e.cnt);
        end
    end

    initial begin
        model_reset();
        // Asynchronous reset mid-cycle, before any clock edge has seen it.
        #3 reset = 1'b1;
        #1 check_reset_values("rst_async");
        @(posedge clock);
        #2 reset = 1'b0;

        drive(0, 1, 0, 0, 0, 0, 0);
        cycle();                             // BOOT -> RUN, pc stays
        cycle();                             // 0xC01
        cycle();                             // 0xC02
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();                  // not ready: hold
        drive(1, 1, 0, 0, 0, 0, 0);
        repeat (2) cycle();                  // stalled: hold

        drive(1, 1, 1, 64'h1000F00D, 0, 0, 0);
        cycle();                             // jump under stall
        drive(0, 1, 0, 0, 0, 0, 0);
        cycle();                             // 0x1000F00E

        drive(0, 1, 1, 64'h1234, 1, 64'hC05, 0);
        cycle();                             // exception beats jump
        drive(0, 1, 0, 0, 1, 64'hAAA, 0);
        cycle();                             // masked exception
        drive(0, 1, 0, 0, 0, 0, 1);
        cycle();                             // eret -> 0xC05

        drive(0, 1, 1, 64'h3FFFFFFF, 0, 0, 0);
        cycle();
        drive(0, 1, 0, 0, 0, 0, 0);
        cycle();                             // wrap to 0
        drive(0, 1, 0, 0, 0, 0, 1);
        cycle();                             // eret with exl=0: plain increment

        drive(0, 1, 1, 64'h55, 1, 64'h77, 1);
        apply_reset("rst_busy");
        cycle();                             // redirects ignored while in BOOT
        cycle();

        for (int i = 0; i < 600; i++) begin
            longint tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (PC_MOD - 1 - $urandom_range(0, 2))
                                              : longint'($urandom() & 32'h3FFF_FFFF);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, tgt,
                  $urandom_range(0, 11) == 0, longint'($urandom() & 32'h3FFF_FFFF),
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 149) == 0)
                apply_reset("rst_rand");
            else
                cycle();
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        check("scoreboard_drained", longint'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
